ms_serial_mul_gen: RTL and testbench

- Generalised successor to the fixed 2..5-input deterministic stochastic multiplier.
- Multiplies NUM_INPUTS unsigned DATA_WIDTH-bit operands exactly, using deterministic unary bitstreams and a parallel popcount accumulator.
- Lane count per operand is parametrised as a power of two. Lane products and popcount are generated for any NUM_INPUTS; there are no hand-coded lane equations.
- All SNG counters run on the single clock with a clock-enable cascade; there is no ripple clocking from overflow outputs.
- Adds a start/busy/done handshake, a held result register, and a zero-operand early exit.

---
 rtl/ms_serial_mul_gen.sv | 136 +++++++++++++
 tb/tb_ms_serial_mul_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_serial_mul_gen.sv
// Exact N-operand multiplier built from deterministic unary bitstreams: each operand
// feeds S parallel comparator lanes, and the popcount of all lane ANDs is accumulated.
module ms_serial_mul_gen #(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_INPUTS  = 2,
    parameter int LOG2_STRIDE = 1,
    parameter int ZERO_SKIP   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out
);
    localparam int W     = DATA_WIDTH;
    localparam int N     = NUM_INPUTS;
    localparam int L     = LOG2_STRIDE;
    localparam int S     = 2**L;
    localparam int LANES = 2**(N*L);
    localparam int PW    = N*L + 1;
    localparam int AW    = N*W;

    localparam logic [W-1:0] INC  = W'(S);
    localparam logic [W:0]   WRAP = (W+1)'(2**W) - (W+1)'(S);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [N-1:0][W-1:0] opnd_q, opnd_d;
    logic [N-1:0][W-1:0] cnt_q, cnt_d, cnt_adv;
    logic [AW-1:0]       acc_q, acc_d, acc_sum;
    logic [AW-1:0]       res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [N-1:0][W-1:0] din;
    logic [N-1:0][S-1:0] lane;
    logic [N-1:0]        wrap, adv, zero;
    logic [LANES-1:0]    prod;
    logic [PW-1:0]       pcnt;
    logic                any_zero;

    assign din = bin_data_in;

    // Counter i only steps when every lower counter is on its last value (enable cascade).
    for (genvar i = 0; i < N; i++) begin : g_sng
        assign wrap[i] = {1'b0, cnt_q[i]} == WRAP;
        assign zero[i] = din[i] == '0;
        if (i == 0) begin : g_first
            assign adv[i] = state_q == RUN;
        end else begin : g_next
            assign adv[i] = (state_q == RUN) & (&wrap[i-1:0]);
        end
        assign cnt_adv[i] = adv[i] ? cnt_q[i] + INC : cnt_q[i];
        for (genvar k = 0; k < S; k++) begin : g_bit
            assign lane[i][k] = ({1'b0, cnt_q[i]} + (W+1)'(k)) < {1'b0, opnd_q[i]};
        end
    end

    // Lane t picks stream bit (t >> j*L) mod S from operand j, covering all S**N tuples.
    for (genvar t = 0; t < LANES; t++) begin : g_prod
        logic [N-1:0] bits;
        for (genvar j = 0; j < N; j++) begin : g_op
            assign bits[j] = lane[j][(t >> (j*L)) % S];
        end
        assign prod[t] = &bits;
    end

    assign pcnt     = PW'($countones(prod));
    assign acc_sum  = acc_q + AW'(pcnt);
    assign any_zero = |zero;

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d = din;
                    cnt_d  = '0;
                    acc_d  = '0;
                    if (ZERO_SKIP != 0 && any_zero) begin
                        res_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = cnt_adv;
                acc_d = acc_sum;
                if (&wrap) begin
                    res_d   = acc_sum;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bin_data_out = res_q;

endmodule

// File: tb/tb_ms_serial_mul_gen.sv
// Bench for ms_serial_mul_gen: three parameter sets share start/rst and are compared every
// cycle against a transaction-level model (product of latched operands after T cycles).
module tb_ms_serial_mul_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] din_a = '0;
    logic [8:0] din_b = '0;
    logic [9:0] din_c = '0;
    logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [5:0] res_a;
    logic [8:0] res_b;
    logic [9:0] res_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ms_serial_mul_gen #(.DATA_WIDTH(3), .NUM_INPUTS(2), .LOG2_STRIDE(1), .ZERO_SKIP(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bin_data_in(din_a),
        .busy(busy_a), .done(done_a), .bin_data_out(res_a));
    ms_serial_mul_gen #(.DATA_WIDTH(3), .NUM_INPUTS(3), .LOG2_STRIDE(1), .ZERO_SKIP(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bin_data_in(din_b),
        .busy(busy_b), .done(done_b), .bin_data_out(res_b));
    ms_serial_mul_gen #(.DATA_WIDTH(5), .NUM_INPUTS(2), .LOG2_STRIDE(2), .ZERO_SKIP(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .bin_data_in(din_c),
        .busy(busy_c), .done(done_c), .bin_data_out(res_c));

    localparam int PWD[3] = '{3, 3, 5};
    localparam int PND[3] = '{2, 3, 2};
    localparam int PLD[3] = '{1, 1, 2};
    localparam int PZD[3] = '{1, 0, 1};

    bit     m_busy[3] = '{0, 0, 0};
    bit     m_done[3] = '{0, 0, 0};
    longint m_res[3]  = '{0, 0, 0};
    longint m_prod[3] = '{0, 0, 0};
    longint m_rem[3]  = '{0, 0, 0};
    int     dc[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_din(input int d);
        case (d)
            0: return 64'(din_a);
            1: return 64'(din_b);
            default: return 64'(din_c);
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int d);
        case (d)
            0: return 64'(res_a);
            1: return 64'(res_b);
            default: return 64'(res_c);
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    // Transaction model: accept in idle, hold busy for (2**W/S)**N cycles, then publish the product.
    task automatic mstep(input int d);
        logic [63:0] ops;
        longint p;
        longint a;
        bit z;
        int w, n;
        w = PWD[d];
        n = PND[d];
        ops = get_din(d);
        m_done[d] = 1'b0;
        if (!m_busy[d]) begin
            if (start) begin
                p = 1;
                z = 1'b0;
                for (int i = 0; i < n; i++) begin
                    a = longint'((ops >> (i*w)) & ((64'd1 << w) - 64'd1));
                    p = p * a;
                    if (a == 0) z = 1'b1;
                end
                if (PZD[d] != 0 && z) begin
                    m_done[d] = 1'b1;
                    m_res[d]  = 0;
                end else begin
                    m_busy[d] = 1'b1;
                    m_prod[d] = p;
                    m_rem[d]  = longint'(1) << ((w - PLD[d]) * n);
                end
            end
        end else begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b1;
                m_res[d]  = m_prod[d];
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
                m_res[d]  = 0;
                m_rem[d]  = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) mstep(d);
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_busy", d), 64'(get_busy(d)), 64'(m_busy[d]));
            chk($sformatf("dut%0d_done", d), 64'(get_done(d)), 64'(m_done[d]));
            chk($sformatf("dut%0d_res", d), get_res(d), 64'(m_res[d]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts negedges after the start edge (first one = c0+1) until each masked DUT pulses done.
    task automatic wait_dones(input int c0, input int bound, input bit [2:0] mask);
        bit all;
        for (int d = 0; d < 3; d++) dc[d] = 0;
        for (int c = c0 + 1; c <= bound; c++) begin
            @(negedge clk);
            all = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (mask[d] && dc[d] == 0 && get_done(d)) dc[d] = c;
                if (mask[d] && dc[d] == 0) all = 1'b0;
            end
            if (all) break;
        end
    endtask

    task automatic wait_idle(input int bound);
        int c;
        c = 0;
        while ((busy_a || busy_b || busy_c) && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", 64'(busy_a || busy_b || busy_c), 64'd0);
    endtask

    function automatic int rnd_op(input int w);
        if ($urandom_range(0, 5) == 0) return 0;
        return int'($urandom_range(1, (1 << w) - 1));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_res_a", 64'(res_a), 64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);
        tick();
        rst = 1'b0;

        // Basic products: 5*7, 7*7*7, 31*31
        din_a = {3'd7, 3'd5};
        din_b = {3'd7, 3'd7, 3'd7};
        din_c = {5'd31, 5'd31};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_dones(0, 120, 3'b111);
        chk("s1_lat", 64'(dc[0]), 64'd17);
        chk("s2_lat", 64'(dc[1]), 64'd65);
        chk("s3_lat", 64'(dc[2]), 64'd65);
        repeat (3) tick();
        chk("s1_res_held", 64'(res_a), 64'd35);
        chk("s2_res", 64'(res_b), 64'd343);
        chk("s3_res", 64'(res_c), 64'd961);

        // Start and operand changes during RUN are ignored; start coincident with done is taken
        din_a = {3'd5, 3'd3};
        din_b = {3'd2, 3'd2, 3'd2};
        din_c = {5'd10, 5'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        din_a = {3'd7, 3'd7};
        din_b = '1;
        din_c = '1;
        tick();
        start = 1'b0;
        wait_dones(4, 40, 3'b001);
        chk("s5_lat", 64'(dc[0]), 64'd17);
        chk("s5_res", 64'(res_a), 64'd15);
        start = 1'b1;
        din_a = {3'd2, 3'd3};
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("s5_b2b_busy", 64'(busy_a), 64'd1);
        wait_dones(1, 40, 3'b001);
        chk("s5_b2b_lat", 64'(dc[0]), 64'd17);
        chk("s5_b2b_res", 64'(res_a), 64'd6);
        wait_idle(100);
        chk("s5_res_b", 64'(res_b), 64'd8);
        chk("s5_res_c", 64'(res_c), 64'd30);

        // Zero operand: early exit where enabled, full run where not
        din_a = {3'd6, 3'd0};
        din_b = {3'd1, 3'd0, 3'd2};
        din_c = {5'd0, 5'd9};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_dones(0, 120, 3'b111);
        chk("s4_lat_a", 64'(dc[0]), 64'd1);
        chk("s4_lat_b", 64'(dc[1]), 64'd65);
        chk("s4_lat_c", 64'(dc[2]), 64'd1);
        chk("s4_res_a", 64'(res_a), 64'd0);
        chk("s4_res_b", 64'(res_b), 64'd0);
        chk("s4_res_c", 64'(res_c), 64'd0);

        // Reset in the middle of a run, then a clean run
        din_a = {3'd7, 3'd5};
        din_b = {3'd3, 3'd3, 3'd3};
        din_c = {5'd5, 5'd5};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_res", 64'(res_a), 64'd0);
        chk("s6_rst_busy", 64'(busy_a), 64'd0);
        chk("s6_rst_done", 64'(done_a), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        din_a = {3'd6, 3'd3};
        din_b = {3'd1, 3'd2, 3'd3};
        din_c = {5'd6, 5'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_dones(0, 120, 3'b111);
        chk("s6_lat", 64'(dc[0]), 64'd17);
        chk("s6_res_a", 64'(res_a), 64'd18);
        chk("s6_res_b", 64'(res_b), 64'd6);
        chk("s6_res_c", 64'(res_c), 64'd18);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            din_a = {3'(rnd_op(3)), 3'(rnd_op(3))};
            din_b = {3'(rnd_op(3)), 3'(rnd_op(3)), 3'(rnd_op(3))};
            din_c = {5'(rnd_op(5)), 5'(rnd_op(5))};
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
